// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared constants and types for the five-stage CPU datapath.
//   DATA_W   : operand / result width
//   REG_W    : register address width
//   PC_W     : program counter width
//   REG_ZERO : hard-wired zero register, never forwarded
//   src_sel_e: which source feeds a decode operand
// -----------------------------------------------------------------------------
package cpu_defs;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int PC_W     = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        SRC_RF  = 2'd0,
        SRC_EXE = 2'd1,
        SRC_MEM = 2'd2
    } src_sel_e;

endpackage

// File: rtl/operand_select.sv
// -----------------------------------------------------------------------------
// operand_select
// Forwarding mux for one decode source register.
// Inputs : src / src_used (register and whether the instruction reads it),
//          rf_value (regfile read data), EXE and MEM destination, write-enable
//          and result, exe_is_load (EXE result not ready yet).
// Outputs: operand  (EXE result > MEM result > regfile data)
//          load_use (this source needs a value a load in EXE has not produced)
// -----------------------------------------------------------------------------
module operand_select
    import cpu_defs::*;
#(
    parameter int DATA_W = cpu_defs::DATA_W,
    parameter int REG_W  = cpu_defs::REG_W
) (
    input  logic [REG_W-1:0]  src,
    input  logic              src_used,
    input  logic [DATA_W-1:0] rf_value,
    input  logic [REG_W-1:0]  exe_wdest,
    input  logic              exe_rf_wen,
    input  logic              exe_is_load,
    input  logic [DATA_W-1:0] exe_result,
    input  logic [REG_W-1:0]  mem_wdest,
    input  logic              mem_rf_wen,
    input  logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] operand,
    output logic              load_use
);

    logic     not_zero;
    logic     hit_exe;
    logic     hit_mem;
    src_sel_e sel;

    // The zero register reads as the regfile value even when a stage claims it.
    assign not_zero = (src != REG_W'(REG_ZERO));
    assign hit_exe  = exe_rf_wen & (exe_wdest == src) & not_zero;
    assign hit_mem  = mem_rf_wen & (mem_wdest == src) & not_zero;

    // An unread source never stalls, even if it collides with a load.
    assign load_use = exe_is_load & src_used & hit_exe;

    always_comb begin
        sel = SRC_RF;
        if (hit_exe)
            sel = SRC_EXE;
        else if (hit_mem)
            sel = SRC_MEM;
    end

    always_comb begin
        operand = rf_value;
        unique case (sel)
            SRC_EXE: operand = exe_result;
            SRC_MEM: operand = mem_result;
            default: operand = rf_value;
        endcase
    end

endmodule

// File: rtl/decode_operand_stage.sv
// -----------------------------------------------------------------------------
// decode_operand_stage
// Decode-stage operand collector and ID/EXE pipeline register.
// Inputs : clk, resetn (sync, active-low), ID_valid/ID_pc, rs/rt with use
//          flags and regfile data, EXE/MEM forwarding info, EXE_allow_in,
//          cancel (flush).
// Outputs: ID_allow_in (combinational), EXE_valid/EXE_pc/EXE_src1/EXE_src2
//          (ID/EXE register), stall_cnt (saturating load-use stall count).
// -----------------------------------------------------------------------------
module decode_operand_stage
    import cpu_defs::*;
#(
    parameter int DATA_W = cpu_defs::DATA_W,
    parameter int REG_W  = cpu_defs::REG_W,
    parameter int PC_W   = cpu_defs::PC_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ID_valid,
    input  logic [PC_W-1:0]   ID_pc,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic [DATA_W-1:0] rs_value,
    input  logic [DATA_W-1:0] rt_value,
    input  logic [REG_W-1:0]  EXE_wdest,
    input  logic              EXE_rf_wen,
    input  logic              EXE_is_load,
    input  logic [DATA_W-1:0] EXE_result,
    input  logic [REG_W-1:0]  MEM_wdest,
    input  logic              MEM_rf_wen,
    input  logic [DATA_W-1:0] MEM_result,
    input  logic              EXE_allow_in,
    input  logic              cancel,
    output logic              ID_allow_in,
    output logic              EXE_valid,
    output logic [PC_W-1:0]   EXE_pc,
    output logic [DATA_W-1:0] EXE_src1,
    output logic [DATA_W-1:0] EXE_src2,
    output logic [CNT_W-1:0]  stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0] src1_p0;
    logic [DATA_W-1:0] src2_p0;
    logic              rs_load_use;
    logic              rt_load_use;
    logic              load_use_p0;
    logic              id_over_p0;

    logic              vld_p1;
    logic [PC_W-1:0]   pc_p1;
    logic [DATA_W-1:0] src1_p1;
    logic [DATA_W-1:0] src2_p1;
    logic [CNT_W-1:0]  stall_cnt_q;

    operand_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_sel_rs (
        .src        (rs),
        .src_used   (rs_used),
        .rf_value   (rs_value),
        .exe_wdest  (EXE_wdest),
        .exe_rf_wen (EXE_rf_wen),
        .exe_is_load(EXE_is_load),
        .exe_result (EXE_result),
        .mem_wdest  (MEM_wdest),
        .mem_rf_wen (MEM_rf_wen),
        .mem_result (MEM_result),
        .operand    (src1_p0),
        .load_use   (rs_load_use)
    );

    operand_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_sel_rt (
        .src        (rt),
        .src_used   (rt_used),
        .rf_value   (rt_value),
        .exe_wdest  (EXE_wdest),
        .exe_rf_wen (EXE_rf_wen),
        .exe_is_load(EXE_is_load),
        .exe_result (EXE_result),
        .mem_wdest  (MEM_wdest),
        .mem_rf_wen (MEM_rf_wen),
        .mem_result (MEM_result),
        .operand    (src2_p0),
        .load_use   (rt_load_use)
    );

    assign load_use_p0 = rs_load_use | rt_load_use;
    assign id_over_p0  = ID_valid & ~load_use_p0;
    assign ID_allow_in = ~ID_valid | (id_over_p0 & EXE_allow_in);

    // ---- ID -> EXE boundary ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            src1_p1     <= '0;
            src2_p1     <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (cancel) begin
                vld_p1 <= 1'b0;
            end else if (EXE_allow_in) begin
                // A stalled instruction becomes a bubble; data regs keep old values.
                vld_p1 <= id_over_p0;
                if (id_over_p0) begin
                    pc_p1   <= ID_pc;
                    src1_p1 <= src1_p0;
                    src2_p1 <= src2_p0;
                end
            end
            // A flushed stall is not a real stall cycle.
            if (ID_valid & load_use_p0 & ~cancel)
                stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign EXE_valid = vld_p1;
    assign EXE_pc    = pc_p1;
    assign EXE_src1  = src1_p1;
    assign EXE_src2  = src2_p1;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_operand_stage.sv
module tb_decode_operand_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ID_valid;
    logic [31:0] ID_pc;
    logic [4:0]  rs, rt;
    logic        rs_used, rt_used;
    logic [31:0] rs_value, rt_value;
    logic [4:0]  EXE_wdest;
    logic        EXE_rf_wen, EXE_is_load;
    logic [31:0] EXE_result;
    logic [4:0]  MEM_wdest;
    logic        MEM_rf_wen;
    logic [31:0] MEM_result;
    logic        EXE_allow_in, cancel;
    logic        ID_allow_in, EXE_valid;
    logic [31:0] EXE_pc, EXE_src1, EXE_src2;
    logic [15:0] stall_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    decode_operand_stage dut (
        .clk         (clk),
        .resetn      (resetn),
        .ID_valid    (ID_valid),
        .ID_pc       (ID_pc),
        .rs          (rs),
        .rt          (rt),
        .rs_used     (rs_used),
        .rt_used     (rt_used),
        .rs_value    (rs_value),
        .rt_value    (rt_value),
        .EXE_wdest   (EXE_wdest),
        .EXE_rf_wen  (EXE_rf_wen),
        .EXE_is_load (EXE_is_load),
        .EXE_result  (EXE_result),
        .MEM_wdest   (MEM_wdest),
        .MEM_rf_wen  (MEM_rf_wen),
        .MEM_result  (MEM_result),
        .EXE_allow_in(EXE_allow_in),
        .cancel      (cancel),
        .ID_allow_in (ID_allow_in),
        .EXE_valid   (EXE_valid),
        .EXE_pc      (EXE_pc),
        .EXE_src1    (EXE_src1),
        .EXE_src2    (EXE_src2),
        .stall_cnt   (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_fwd();
        EXE_wdest = 0; EXE_rf_wen = 0; EXE_is_load = 0; EXE_result = 0;
        MEM_wdest = 0; MEM_rf_wen = 0; MEM_result = 0;
    endtask

    task automatic load_use_setup();
        ID_valid = 1; rs = 3; rt = 7; rs_used = 1; rt_used = 1;
        EXE_is_load = 1; EXE_wdest = 7; EXE_rf_wen = 1; MEM_rf_wen = 0;
    endtask

    initial begin
        resetn = 0; ID_valid = 0; ID_pc = 0; rs = 0; rt = 0;
        rs_used = 0; rt_used = 0; rs_value = 0; rt_value = 0;
        clear_fwd();
        EXE_allow_in = 1; cancel = 0;
        tick(); tick();
        chk("rst_valid", EXE_valid, 0);
        chk("rst_pc",    EXE_pc,    0);
        chk("rst_src1",  EXE_src1,  0);
        chk("rst_src2",  EXE_src2,  0);
        chk("rst_cnt",   stall_cnt, 0);
        resetn = 1;

        // No hazard
        ID_valid = 1; ID_pc = 32'h100; rs = 3; rt = 4; rs_used = 1; rt_used = 1;
        rs_value = 32'h11; rt_value = 32'h22;
        settle();
        chk("nohaz_allow", ID_allow_in, 1);
        tick();
        chk("nohaz_valid", EXE_valid, 1);
        chk("nohaz_pc",    EXE_pc,    32'h100);
        chk("nohaz_src1",  EXE_src1,  32'h11);
        chk("nohaz_src2",  EXE_src2,  32'h22);

        // Double hit: EXE wins over MEM
        ID_pc = 32'h104; rs = 5;
        EXE_wdest = 5; EXE_rf_wen = 1; EXE_result = 32'hAA;
        MEM_wdest = 5; MEM_rf_wen = 1; MEM_result = 32'hBB;
        tick();
        chk("dbl_src1", EXE_src1, 32'hAA);
        chk("dbl_src2", EXE_src2, 32'h22);
        // MEM only
        ID_pc = 32'h108; EXE_rf_wen = 0;
        tick();
        chk("mem_src1", EXE_src1, 32'hBB);
        // Register zero never forwarded
        ID_pc = 32'h10C; rs = 0; EXE_wdest = 0; EXE_rf_wen = 1; MEM_wdest = 0;
        tick();
        chk("zero_src1", EXE_src1, 32'h11);
        chk("zero_pc",   EXE_pc,   32'h10C);

        // Load-use on rt
        clear_fwd();
        ID_pc = 32'h110; load_use_setup();
        settle();
        chk("lu_allow", ID_allow_in, 0);
        tick();
        chk("lu_bubble", EXE_valid, 0);
        chk("lu_cnt",    stall_cnt, 1);
        chk("lu_keep1",  EXE_src1,  32'h11);
        chk("lu_keeppc", EXE_pc,    32'h10C);
        EXE_is_load = 0; EXE_rf_wen = 0;
        MEM_wdest = 7; MEM_rf_wen = 1; MEM_result = 32'h55;
        settle();
        chk("lu_res_allow", ID_allow_in, 1);
        tick();
        chk("lu_res_valid", EXE_valid, 1);
        chk("lu_res_src2",  EXE_src2,  32'h55);
        chk("lu_res_pc",    EXE_pc,    32'h110);
        chk("lu_res_cnt",   stall_cnt, 1);

        // Same setup, rt not read: no stall, EXE result still forwarded
        clear_fwd();
        ID_pc = 32'h114; load_use_setup(); rt_used = 0; EXE_result = 32'h77;
        settle();
        chk("nouse_allow", ID_allow_in, 1);
        tick();
        chk("nouse_valid", EXE_valid, 1);
        chk("nouse_src2",  EXE_src2,  32'h77);
        chk("nouse_cnt",   stall_cnt, 1);

        // Backpressure
        clear_fwd();
        ID_pc = 32'h120; rs = 3; rt = 4; rt_used = 1;
        rs_value = 32'h31; rt_value = 32'h32; EXE_allow_in = 0;
        settle();
        chk("bp_allow", ID_allow_in, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", EXE_valid, 1);
            chk("bp_hold_pc",    EXE_pc,    32'h114);
            chk("bp_hold_src1",  EXE_src1,  32'h11);
        end
        EXE_allow_in = 1;
        tick();
        chk("bp_rel_valid", EXE_valid, 1);
        chk("bp_rel_pc",    EXE_pc,    32'h120);
        chk("bp_rel_src1",  EXE_src1,  32'h31);
        ID_valid = 0;
        settle();
        chk("idle_allow", ID_allow_in, 1);
        tick();
        chk("bp_once", EXE_valid, 0);

        // Cancel together with load-use
        ID_pc = 32'h130; load_use_setup(); cancel = 1;
        tick();
        chk("cxl_valid", EXE_valid, 0);
        chk("cxl_cnt",   stall_cnt, 1);
        cancel = 0;
        tick();
        chk("stall_cnt2", stall_cnt, 2);
        resetn = 0;
        tick();
        chk("mid_rst_valid", EXE_valid, 0);
        chk("mid_rst_pc",    EXE_pc,    0);
        chk("mid_rst_src1",  EXE_src1,  0);
        chk("mid_rst_src2",  EXE_src2,  0);
        chk("mid_rst_cnt",   stall_cnt, 0);
        resetn = 1;

        // Saturation: persistent stall
        for (int i = 0; i < 65535; i++) tick();
        chk("sat_full", stall_cnt, 16'hFFFF);
        chk("sat_bubble", EXE_valid, 0);
        tick();
        chk("sat_hold", stall_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
